// File: rtl/sobel_window_if.sv
// Pixel-strobe bus into the Sobel window stage: three column-aligned row taps
// plus direction select in, saturated gradient magnitude and frame markers out.
interface sobel_window_if #(
  parameter int PIX_W = 12
);
  logic             en;
  logic [PIX_W-1:0] row0_in;
  logic [PIX_W-1:0] row1_in;
  logic [PIX_W-1:0] row2_in;
  logic             dir;
  logic [PIX_W-1:0] pixel_out;
  logic             out_valid;
  logic             frame_done;

  modport master (
    output en, row0_in, row1_in, row2_in, dir,
    input  pixel_out, out_valid, frame_done
  );

  modport slave (
    input  en, row0_in, row1_in, row2_in, dir,
    output pixel_out, out_valid, frame_done
  );
endinterface

// File: rtl/sobel_window.sv
// 3x3 sliding window with Sobel Gx/Gy kernel: stage 1 shifts the window and
// registers the signed gradient, stage 2 takes |G|, saturates and masks borders.
module sobel_window #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int PIX_W  = 12
) (
  input  logic           clk,
  input  logic           rst,
  sobel_window_if.slave  px
);

  localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int G_W   = PIX_W + 4;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
  localparam logic [G_W-1:0]   SAT_MAX  = G_W'((1 << PIX_W) - 1);

  typedef logic [PIX_W-1:0]      pix_t;
  typedef logic signed [G_W-1:0] g_t;

  pix_t             win_q [3][3];
  pix_t             win_d [3][3];
  logic [COL_W-1:0] col_cnt_q, col_cnt_d;
  logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
  logic             valid_s1_q, valid_s1_d;
  logic             border_s1_q, border_s1_d;
  logic             last_s1_q, last_s1_d;
  g_t               g_s1_q, g_s1_d;
  pix_t             pixel_out_q, pixel_out_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_done_q, frame_done_d;

  logic [G_W-1:0]   mag;
  pix_t             sat_mag;

  function automatic g_t ext(input pix_t p);
    return $signed({4'b0000, p});
  endfunction

  function automatic g_t grad_x(input pix_t w [3][3]);
    return (ext(w[0][2]) + (ext(w[1][2]) <<< 1) + ext(w[2][2]))
         - (ext(w[0][0]) + (ext(w[1][0]) <<< 1) + ext(w[2][0]));
  endfunction

  function automatic g_t grad_y(input pix_t w [3][3]);
    return (ext(w[2][0]) + (ext(w[2][1]) <<< 1) + ext(w[2][2]))
         - (ext(w[0][0]) + (ext(w[0][1]) <<< 1) + ext(w[0][2]));
  endfunction

  // Gradient is taken from the post-shift window so stage 2 never depends on
  // a window that may shift again on the same edge it registers.
  always_comb begin
    win_d       = win_q;
    col_cnt_d   = col_cnt_q;
    row_cnt_d   = row_cnt_q;
    valid_s1_d  = 1'b0;
    border_s1_d = border_s1_q;
    last_s1_d   = last_s1_q;
    g_s1_d      = g_s1_q;
    if (px.en) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = px.row2_in;
      win_d[1][2] = px.row1_in;
      win_d[2][2] = px.row0_in;

      valid_s1_d  = 1'b1;
      border_s1_d = (col_cnt_q < COL_W'(2)) || (row_cnt_q < ROW_W'(2));
      last_s1_d   = (col_cnt_q == COL_LAST) && (row_cnt_q == ROW_LAST);
      g_s1_d      = px.dir ? grad_y(win_d) : grad_x(win_d);

      if (col_cnt_q == COL_LAST) begin
        col_cnt_d = '0;
        row_cnt_d = (row_cnt_q == ROW_LAST) ? '0 : row_cnt_q + 1'b1;
      end else begin
        col_cnt_d = col_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    mag          = g_s1_q[G_W-1] ? G_W'(-g_s1_q) : G_W'(g_s1_q);
    sat_mag      = (mag > SAT_MAX) ? SAT_MAX[PIX_W-1:0] : mag[PIX_W-1:0];
    pixel_out_d  = pixel_out_q;
    out_valid_d  = valid_s1_q;
    frame_done_d = valid_s1_q & last_s1_q;
    if (valid_s1_q) begin
      pixel_out_d = border_s1_q ? '0 : sat_mag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q        <= '{default: '0};
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      valid_s1_q   <= 1'b0;
      border_s1_q  <= 1'b0;
      last_s1_q    <= 1'b0;
      g_s1_q       <= '0;
      pixel_out_q  <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      win_q        <= win_d;
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      valid_s1_q   <= valid_s1_d;
      border_s1_q  <= border_s1_d;
      last_s1_q    <= last_s1_d;
      g_s1_q       <= g_s1_d;
      pixel_out_q  <= pixel_out_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign px.pixel_out  = pixel_out_q;
  assign px.out_valid  = out_valid_q;
  assign px.frame_done = frame_done_q;

endmodule
